// File: rtl/mem_subsys_hs.sv
// Memory subsystem with MAR/MDR registers, a single-port synchronous array and a
// fixed-latency IDLE/ACCESS handshake (busy, done and err are registered).
module mem_subsys_hs #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] busInMDR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr;
    logic              complete_c;

    logic [DATA_W-1:0] mem [DEPTH];

    assign complete_c = (state == ACCESS) && (cnt == CNT_W'(0));
    assign busInMDR   = mdr;

    // Control FSM, MAR/MDR and the latency counter; clr overrides a completion due at the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            op_wr <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (MARin) mar <= bus[ADDR_W-1:0];
                    if (MDRin) mdr <= bus;
                    if (read ^ write) begin
                        state <= ACCESS;
                        busy  <= 1'b1;
                        op_wr <= write;
                        cnt   <= CNT_W'(LAT - 1);
                    end else if (read && write) begin
                        err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!op_wr) mdr <= mem[mar];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write port; never reset, and an access aborted by clr leaves it untouched.
    always_ff @(posedge clk) begin
        if (!clr && complete_c && op_wr) mem[mar] <= mdr;
    end

endmodule

// File: tb/tb_mem_subsys_hs.sv
// Self-checking bench: four mem_subsys_hs instances (LAT 2/1/15 and a 16x16 variant)
// driven by directed and randomized transactions against a transaction-level model.
module tb_mem_subsys_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr   [4];
    logic [31:0] bus   [4];
    logic        marin [4];
    logic        mdrin [4];
    logic        rd    [4];
    logic        wr    [4];
    logic [31:0] mdr_o [4];
    logic        busy_o[4];
    logic        done_o[4];
    logic        err_o [4];
    logic [15:0] mdr_w;
    logic [15:0] bus_w;

    assign mdr_o[3] = {16'h0000, mdr_w};
    assign bus_w    = bus[3][15:0];

    int          lat  [4] = '{2, 1, 15, 2};
    logic [31:0] dmask[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] amask[4] = '{32'h1FF, 32'h1FF, 32'h1FF, 32'h00F};

    logic [31:0] mem_m[4][512];
    bit          vld  [4][512];
    logic [31:0] mar_m[4];
    logic [31:0] mdr_m[4];

    int checks = 0;
    int errors = 0;

    mem_subsys_hs #(.DATA_W(32), .ADDR_W(9), .LAT(2)) dut0 (
        .clk(clk), .clr(clr[0]), .bus(bus[0]), .MARin(marin[0]), .MDRin(mdrin[0]),
        .read(rd[0]), .write(wr[0]), .busInMDR(mdr_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .err(err_o[0]));

    mem_subsys_hs #(.DATA_W(32), .ADDR_W(9), .LAT(1)) dut1 (
        .clk(clk), .clr(clr[1]), .bus(bus[1]), .MARin(marin[1]), .MDRin(mdrin[1]),
        .read(rd[1]), .write(wr[1]), .busInMDR(mdr_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .err(err_o[1]));

    mem_subsys_hs #(.DATA_W(32), .ADDR_W(9), .LAT(15)) dut2 (
        .clk(clk), .clr(clr[2]), .bus(bus[2]), .MARin(marin[2]), .MDRin(mdrin[2]),
        .read(rd[2]), .write(wr[2]), .busInMDR(mdr_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .err(err_o[2]));

    mem_subsys_hs #(.DATA_W(16), .ADDR_W(4), .LAT(2)) dutw (
        .clk(clk), .clr(clr[3]), .bus(bus_w), .MARin(marin[3]), .MDRin(mdrin[3]),
        .read(rd[3]), .write(wr[3]), .busInMDR(mdr_w), .busy(busy_o[3]),
        .done(done_o[3]), .err(err_o[3]));

    // One transaction on instance k, starting and ending at a falling edge; model updated as it completes.
    task automatic issue(input int k, input bit mi, input bit di, input bit r, input bit w,
                         input logic [31:0] bv);
        int a;
        marin[k] = mi; mdrin[k] = di; rd[k] = r; wr[k] = w; bus[k] = bv;
        @(negedge clk);
        marin[k] = 1'b0; mdrin[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
        if (mi) mar_m[k] = bv & amask[k];
        if (di) mdr_m[k] = bv & dmask[k];
        a = int'(mar_m[k]);
        if (r && w) begin
            checks++;
            if (err_o[k] !== 1'b1 || busy_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL conflict_flags dut%0d err=%b busy=%b done=%b required 1/0/0",
                         k, err_o[k], busy_o[k], done_o[k]);
            end
            checks++;
            if (mdr_o[k] !== mdr_m[k]) begin
                errors++;
                $display("FAIL conflict_mdr dut%0d got %h required %h", k, mdr_o[k], mdr_m[k]);
            end
            @(negedge clk);
            checks++;
            if (err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL conflict_err_width dut%0d err=%b required 0", k, err_o[k]);
            end
        end else if (r || w) begin
            for (int i = 1; i <= lat[k]; i++) begin
                checks++;
                if (busy_o[k] !== 1'b1 || done_o[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_phase dut%0d cycle %0d busy=%b done=%b required 1/0",
                             k, i, busy_o[k], done_o[k]);
                end
                @(negedge clk);
            end
            checks++;
            if (done_o[k] !== 1'b1 || busy_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse dut%0d done=%b busy=%b required 1/0",
                         k, done_o[k], busy_o[k]);
            end
            if (r) mdr_m[k] = mem_m[k][a];
            else begin
                mem_m[k][a] = mdr_m[k];
                vld[k][a]   = 1'b1;
            end
            checks++;
            if (mdr_o[k] !== mdr_m[k]) begin
                errors++;
                $display("FAIL access_mdr dut%0d %s addr %h got %h required %h",
                         k, r ? "read" : "write", a, mdr_o[k], mdr_m[k]);
            end
        end else begin
            checks++;
            if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_flags dut%0d busy=%b done=%b err=%b required 0/0/0",
                         k, busy_o[k], done_o[k], err_o[k]);
            end
            checks++;
            if (mdr_o[k] !== mdr_m[k]) begin
                errors++;
                $display("FAIL load_mdr dut%0d got %h required %h", k, mdr_o[k], mdr_m[k]);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b1; rd[k] = 1'b1; marin[k] = 1'b1; bus[k] = $urandom;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b0; rd[k] = 1'b0; marin[k] = 1'b0;
            mar_m[k] = '0; mdr_m[k] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d busy=%b done=%b err=%b required 0/0/0",
                         k, busy_o[k], done_o[k], err_o[k]);
            end
            checks++;
            if (mdr_o[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mdr dut%0d got %h required 0", k, mdr_o[k]);
            end
        end
    endtask

    task automatic test_basic();
        issue(0, 1, 0, 0, 0, 32'h0000_0005);
        issue(0, 0, 1, 0, 0, 32'hDEAD_BEEF);
        issue(0, 0, 0, 0, 1, 32'h0);
        issue(0, 0, 1, 0, 0, 32'h0);
        issue(0, 0, 0, 1, 0, 32'h0);
        checks++;
        if (mdr_o[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_readback got %h required deadbeef", mdr_o[0]);
        end
    endtask

    task automatic test_conflict();
        issue(0, 0, 0, 1, 1, $urandom);
        issue(0, 1, 0, 1, 0, 32'h0000_0005);
    endtask

    task automatic test_ignored_busy();
        int dones;
        issue(0, 1, 1, 0, 1, 32'hCAFE_01FF);
        issue(0, 1, 1, 0, 1, 32'h1357_9005);
        marin[0] = 1'b1; rd[0] = 1'b1; bus[0] = 32'h0000_0005;
        @(negedge clk);
        marin[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; bus[0] = 32'h0000_01FF;
        @(negedge clk);
        marin[0] = 1'b0; wr[0] = 1'b0;
        dones = 0;
        for (int j = 0; j < 10; j++) begin
            if (done_o[0] === 1'b1) dones++;
            @(negedge clk);
        end
        mar_m[0] = 32'h5;
        mdr_m[0] = mem_m[0][5];
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_ignore_dones got %0d required 1", dones);
        end
        checks++;
        if (mdr_o[0] !== 32'h1357_9005) begin
            errors++;
            $display("FAIL busy_ignore_mdr got %h required 13579005", mdr_o[0]);
        end
        issue(0, 0, 0, 1, 0, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        int dones;
        issue(0, 1, 1, 0, 1, 32'hA5A5_0010);
        issue(0, 1, 0, 0, 0, 32'h0000_0010);
        issue(0, 0, 1, 0, 0, 32'h1234_5678);
        wr[0] = 1'b1;
        @(negedge clk);
        wr[0] = 1'b0; clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        mar_m[0] = '0; mdr_m[0] = '0;
        checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || mdr_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL midwrite_reset busy=%b done=%b mdr=%h required 0/0/0",
                     busy_o[0], done_o[0], mdr_o[0]);
        end
        dones = 0;
        for (int j = 0; j < 5; j++) begin
            if (done_o[0] === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midwrite_done got %0d pulses required 0", dones);
        end
        issue(0, 1, 0, 1, 0, 32'h0000_0010);
        checks++;
        if (mdr_o[0] !== 32'hA5A5_0010) begin
            errors++;
            $display("FAIL midwrite_memory got %h required a5a50010", mdr_o[0]);
        end
    endtask

    task automatic test_back_to_back(input int k);
        int per, m, dones;
        logic [31:0] v;
        per = lat[k] + 1;
        m   = 3 * per;
        v   = ($urandom & ~amask[k] & dmask[k]) | 32'h6;
        issue(k, 1, 1, 0, 1, v);
        rd[k] = 1'b1;
        dones = 0;
        for (int j = 1; j <= m; j++) begin
            @(negedge clk);
            if (j == m) rd[k] = 1'b0;
            if (done_o[k] === 1'b1) dones++;
            checks++;
            if (busy_o[k] !== ((j % per) != 0) || done_o[k] !== ((j % per) == 0)) begin
                errors++;
                $display("FAIL b2b_timing dut%0d cycle %0d busy=%b done=%b required %b/%b",
                         k, j, busy_o[k], done_o[k], (j % per) != 0, (j % per) == 0);
            end
        end
        mdr_m[k] = mem_m[k][6];
        checks++;
        if (dones != 3 || mdr_o[k] !== mdr_m[k]) begin
            errors++;
            $display("FAIL b2b_result dut%0d dones=%0d mdr=%h required 3 %h",
                     k, dones, mdr_o[k], mdr_m[k]);
        end
        @(negedge clk);
        checks++;
        if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release dut%0d busy=%b done=%b required 0/0",
                     k, busy_o[k], done_o[k]);
        end
    endtask

    task automatic test_width();
        issue(3, 1, 0, 0, 0, 32'h0000_000F);
        issue(3, 0, 1, 0, 1, 32'h0000_A5A5);
        issue(3, 1, 0, 0, 0, 32'h0000_0000);
        issue(3, 0, 1, 0, 1, 32'h0000_5A5A);
        issue(3, 1, 0, 1, 0, 32'h0000_000F);
        checks++;
        if (mdr_o[3] !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL width_read_f got %h required a5a5", mdr_o[3]);
        end
        issue(3, 1, 0, 1, 0, 32'h0000_0000);
        checks++;
        if (mdr_o[3] !== 32'h0000_5A5A) begin
            errors++;
            $display("FAIL width_read_0 got %h required 5a5a", mdr_o[3]);
        end
        issue(3, 1, 0, 0, 0, 32'h0000_0003);
        issue(3, 0, 1, 0, 1, 32'h0000_3C3C);
        issue(3, 0, 1, 0, 0, 32'h0000_0000);
        issue(3, 1, 0, 1, 0, 32'h0000_FFF3);
        checks++;
        if (mdr_o[3] !== 32'h0000_3C3C) begin
            errors++;
            $display("FAIL width_mar_trunc got %h required 3c3c", mdr_o[3]);
        end
    endtask

    task automatic test_random(input int k, input int n);
        int op, tgt;
        bit mi, di, r, w;
        logic [31:0] addr, bv;
        for (int t = 0; t < n; t++) begin
            op   = $urandom_range(0, 7);
            mi   = 1'($urandom);
            di   = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? ($urandom & amask[k]) : 32'($urandom_range(0, 7));
            bv   = ($urandom & ~amask[k]) | addr;
            r    = (op >= 2 && op <= 4) || op == 7;
            w    = (op >= 5);
            tgt  = int'(mi ? addr : mar_m[k]);
            if (r && !w && !vld[k][tgt]) begin
                r = 1'b0;
                w = 1'b1;
            end
            issue(k, mi, di, r, w, bv);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b1; bus[k] = '0; marin[k] = 1'b0; mdrin[k] = 1'b0;
            rd[k] = 1'b0; wr[k] = 1'b0; mar_m[k] = '0; mdr_m[k] = '0;
            for (int a = 0; a < 512; a++) vld[k][a] = 1'b0;
        end
        test_reset();
        test_basic();
        test_conflict();
        test_ignored_busy();
        test_reset_mid_write();
        for (int k = 0; k < 3; k++) test_back_to_back(k);
        test_width();
        for (int k = 0; k < 4; k++) test_random(k, 40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
